// File: rtl/pe_pkg.sv
// Shared PE definitions: dataflow encodings, stage-count legality and the
// rounding right-shift applied to the drained accumulator.
package pe_pkg;

   localparam logic        DF_OS      = 1'b0;
   localparam logic        DF_WS      = 1'b1;
   localparam int unsigned MAX_STAGES = 4;
   localparam int unsigned RS_W       = 64;

   function automatic logic stages_ok(input int unsigned n);
      return n <= MAX_STAGES;
   endfunction

   // x must arrive sign-extended; RS_W headroom covers the ACC_W+1 bit sum.
   function automatic logic signed [RS_W-1:0] round_shift(
      input logic signed [RS_W-1:0] x,
      input logic        [31:0]     shift,
      input int unsigned            acc_w
   );
      logic [31:0]            s;
      logic signed [RS_W-1:0] bias;
      logic signed [RS_W-1:0] sum;
      s = (shift > 32'(acc_w - 1)) ? 32'(acc_w - 1) : shift;
      if (s == 32'd0) return x;
      bias = RS_W'(1) << (s - 32'd1);
      sum  = x + bias;
      return sum >>> s;
   endfunction

endpackage

// File: rtl/pe_pipe_stage.sv
// DEPTH-deep retiming shift register with async reset; DEPTH=0 is a plain wire.
module pe_pipe_stage #(
   parameter int unsigned W     = 1,
   parameter int unsigned DEPTH = 1
) (
   input  logic         CLK,
   input  logic         RST_N,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   if (DEPTH == 0) begin : g_wire
      logic unused_clk_rst;
      assign unused_clk_rst = CLK ^ RST_N;
      assign q = d;
   end else begin : g_regs
      localparam int unsigned SR_W = DEPTH * W;
      logic [SR_W-1:0] sr;

      always_ff @(posedge CLK or negedge RST_N) begin
         if (!RST_N) sr <= '0;
         else        sr <= SR_W'({sr, d});
      end

      assign q = sr[SR_W-1 -: W];
   end

endmodule

// File: rtl/pe_dual_buf_pipe.sv
// Systolic PE with double-buffered c1/c2, WS/OS dataflow, rounding drain of the
// idle buffer and configurable input/output retiming.
module pe_dual_buf_pipe
   import pe_pkg::*;
#(
   parameter int unsigned IN_W       = 8,
   parameter int unsigned ACC_W      = 19,
   parameter int unsigned SHIFT_W    = 6,
   parameter int unsigned IN_STAGES  = 1,
   parameter int unsigned OUT_STAGES = 1
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic [IN_W-1:0]    io_in_a,
   input  logic [ACC_W-1:0]   io_in_b,
   input  logic [ACC_W-1:0]   io_in_d,
   input  logic               io_in_valid,
   input  logic               io_in_dataflow,
   input  logic [SHIFT_W-1:0] io_in_control_shift,
   input  logic               io_in_control_propagate,
   output logic [IN_W-1:0]    io_out_a,
   output logic [ACC_W-1:0]   io_out_b,
   output logic [ACC_W-1:0]   io_out_c,
   output logic               io_out_valid,
   output logic [SHIFT_W-1:0] io_out_control_shift,
   output logic               io_out_control_propagate
);

   if (!stages_ok(IN_STAGES) || !stages_ok(OUT_STAGES)) begin : g_bad_stages
      $error("pe_dual_buf_pipe: IN_STAGES and OUT_STAGES must be in 0..4");
   end

   typedef struct packed {
      logic [IN_W-1:0]    a;
      logic [ACC_W-1:0]   b;
      logic [ACC_W-1:0]   d;
      logic               valid;
      logic               dataflow;
      logic [SHIFT_W-1:0] shift;
      logic               prop;
   } in_beat_t;

   typedef struct packed {
      logic [IN_W-1:0]    a;
      logic [ACC_W-1:0]   b;
      logic [ACC_W-1:0]   c;
      logic               valid;
      logic [SHIFT_W-1:0] shift;
      logic               prop;
   } out_beat_t;

   in_beat_t  pin_in;
   in_beat_t  core_in;
   out_beat_t core_out;
   out_beat_t pin_out;

   assign pin_in = {io_in_a, io_in_b, io_in_d, io_in_valid, io_in_dataflow,
                    io_in_control_shift, io_in_control_propagate};

   pe_pipe_stage #(.W($bits(in_beat_t)), .DEPTH(IN_STAGES)) u_in_stage (
      .CLK   (CLK),
      .RST_N (RST_N),
      .d     (pin_in),
      .q     (core_in)
   );

   logic signed [ACC_W-1:0] c1;
   logic signed [ACC_W-1:0] c2;
   logic signed [ACC_W-1:0] act;
   logic signed [ACC_W-1:0] idle;
   logic signed [ACC_W-1:0] a_ext;
   logic signed [ACC_W-1:0] prod_ws;
   logic signed [ACC_W-1:0] act_acc;

   // Core datapath: buffer roles follow this beat's propagate bit.
   always_comb begin
      core_out       = '0;
      act            = core_in.prop ? c2 : c1;
      idle           = core_in.prop ? c1 : c2;
      a_ext          = ACC_W'(signed'(core_in.a));
      prod_ws        = a_ext * act;
      act_acc        = act + a_ext * signed'(core_in.b);
      core_out.a     = core_in.a;
      core_out.b     = (core_in.dataflow == DF_WS) ? core_in.b + prod_ws : core_in.b;
      core_out.c     = ACC_W'(round_shift(RS_W'(idle), 32'(core_in.shift), ACC_W));
      core_out.valid = core_in.valid;
      core_out.shift = core_in.shift;
      core_out.prop  = core_in.prop;
   end

   // Idle buffer takes d; active buffer accumulates only in OS.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         c1 <= '0;
         c2 <= '0;
      end else if (core_in.valid) begin
         if (core_in.prop) begin
            c1 <= core_in.d;
            if (core_in.dataflow == DF_OS) c2 <= act_acc;
         end else begin
            c2 <= core_in.d;
            if (core_in.dataflow == DF_OS) c1 <= act_acc;
         end
      end
   end

   pe_pipe_stage #(.W($bits(out_beat_t)), .DEPTH(OUT_STAGES)) u_out_stage (
      .CLK   (CLK),
      .RST_N (RST_N),
      .d     (core_out),
      .q     (pin_out)
   );

   assign io_out_a                 = pin_out.a;
   assign io_out_b                 = pin_out.b;
   assign io_out_c                 = pin_out.c;
   assign io_out_valid             = pin_out.valid;
   assign io_out_control_shift     = pin_out.shift;
   assign io_out_control_propagate = pin_out.prop;

endmodule

// File: tb/tb_pe_dual_buf_pipe.sv
// Scoreboard bench: three PE instances (1/1, 0/0, 3/2 stages) share one
// directed stimulus stream; a negedge monitor checks values and latency.
module tb_pe_dual_buf_pipe;

   localparam int unsigned IN_W    = 8;
   localparam int unsigned ACC_W   = 19;
   localparam int unsigned SHIFT_W = 6;
   localparam int          NDUT    = 3;

   logic               CLK = 1'b0;
   logic               RST_N = 1'b0;
   logic [IN_W-1:0]    in_a = '0;
   logic [ACC_W-1:0]   in_b = '0;
   logic [ACC_W-1:0]   in_d = '0;
   logic               in_valid = 1'b0;
   logic               in_df = 1'b0;
   logic [SHIFT_W-1:0] in_shift = '0;
   logic               in_prop = 1'b0;

   logic [IN_W-1:0]    o_a     [NDUT];
   logic [ACC_W-1:0]   o_b     [NDUT];
   logic [ACC_W-1:0]   o_c     [NDUT];
   logic               o_v     [NDUT];
   logic [SHIFT_W-1:0] o_shift [NDUT];
   logic               o_prop  [NDUT];

   always #5 CLK = ~CLK;

   for (genvar k = 0; k < NDUT; k++) begin : g_dut
      localparam int unsigned IS = (k == 0) ? 1 : (k == 1) ? 0 : 3;
      localparam int unsigned OS = (k == 0) ? 1 : (k == 1) ? 0 : 2;
      pe_dual_buf_pipe #(
         .IN_W(IN_W), .ACC_W(ACC_W), .SHIFT_W(SHIFT_W),
         .IN_STAGES(IS), .OUT_STAGES(OS)
      ) u_dut (
         .CLK                      (CLK),
         .RST_N                    (RST_N),
         .io_in_a                  (in_a),
         .io_in_b                  (in_b),
         .io_in_d                  (in_d),
         .io_in_valid              (in_valid),
         .io_in_dataflow           (in_df),
         .io_in_control_shift      (in_shift),
         .io_in_control_propagate  (in_prop),
         .io_out_a                 (o_a[k]),
         .io_out_b                 (o_b[k]),
         .io_out_c                 (o_c[k]),
         .io_out_valid             (o_v[k]),
         .io_out_control_shift     (o_shift[k]),
         .io_out_control_propagate (o_prop[k])
      );
   end

   function automatic int lat(input int k);
      case (k)
         0:       return 2;
         1:       return 0;
         default: return 5;
      endcase
   endfunction

   typedef struct {
      int a;
      int b;
      int c;
      int shift;
      int prop;
      int cyc;
   } exp_t;

   exp_t sbq [NDUT][$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   bit   done     = 1'b0;
   bit   drained  = 1'b0;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string name, input int k, input longint got, input longint exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s dut%0d: got %0d expected %0d (t=%0t)", name, k, got, exp, $time);
      end
   endtask

   // Monitor: reset forces zero outputs; otherwise every valid output pops the scoreboard.
   exp_t e;
   always @(negedge CLK) begin
      for (int k = 0; k < NDUT; k++) begin
         if (!RST_N) begin
            check("rst_valid", k, longint'(o_v[k]), 0);
            check("rst_a", k, $signed(o_a[k]), 0);
            check("rst_b", k, $signed(o_b[k]), 0);
            check("rst_c", k, $signed(o_c[k]), 0);
         end else if (o_v[k]) begin
            if (sbq[k].size() == 0) begin
               check("unexpected_valid", k, 1, 0);
            end else begin
               e = sbq[k].pop_front();
               check("latency", k, cyc - e.cyc, lat(k));
               check("out_a", k, $signed(o_a[k]), e.a);
               check("out_b", k, $signed(o_b[k]), e.b);
               check("out_c", k, $signed(o_c[k]), e.c);
               check("out_shift", k, longint'(o_shift[k]), e.shift);
               check("out_prop", k, longint'(o_prop[k]), e.prop);
            end
         end
      end
      if (done && !drained) begin
         for (int k = 0; k < NDUT; k++) check("missing_beats", k, sbq[k].size(), 0);
         drained = 1'b1;
      end
   end

   task automatic beat(input int va, input int vb, input int vd, input int vdf,
                       input int vsh, input int vp, input int eb, input int ec);
      exp_t x;
      @(posedge CLK);
      #1;
      in_a     = IN_W'(va);
      in_b     = ACC_W'(vb);
      in_d     = ACC_W'(vd);
      in_valid = 1'b1;
      in_df    = 1'(vdf);
      in_shift = SHIFT_W'(vsh);
      in_prop  = 1'(vp);
      x.a = va; x.b = eb; x.c = ec; x.shift = vsh; x.prop = vp; x.cyc = cyc;
      for (int k = 0; k < NDUT; k++) sbq[k].push_back(x);
   endtask

   // Junk data with valid low: must not disturb c1/c2.
   task automatic gap(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge CLK);
         #1;
         in_valid = 1'b0;
         in_a = IN_W'(7); in_b = ACC_W'(9); in_d = ACC_W'(99);
         in_df = 1'b0; in_prop = 1'b1; in_shift = '0;
      end
   endtask

   localparam int WS = 1;
   localparam int OS = 0;

   initial begin
      repeat (3) @(posedge CLK);
      #2 RST_N = 1'b1;

      //   a   b       d        df  sh  p   exp_b    exp_c
      beat(0,  0,      5,       WS, 0,  1,  0,       0);
      beat(3,  10,     7,       WS, 0,  0,  25,      0);
      beat(2,  1,      0,       WS, 0,  1,  15,      5);
      beat(2,  4,      0,       OS, 0,  0,  4,       7);
      beat(-3, 5,      0,       OS, 0,  0,  5,       0);
      beat(0,  0,      0,       OS, 0,  1,  0,       -7);
      beat(0,  0,      23,      WS, 0,  1,  0,       0);
      beat(0,  0,      -6,      WS, 2,  1,  0,       6);
      beat(0,  0,      262143,  WS, 2,  1,  0,       -1);
      beat(0,  0,      131071,  WS, 63, 1,  0,       1);
      beat(0,  0,      0,       WS, 63, 1,  0,       0);
      beat(0,  0,      131072,  WS, 0,  0,  0,       0);
      beat(4,  0,      0,       WS, 0,  1,  0,       0);
      beat(3,  0,      0,       WS, 0,  1,  -131072, 0);
      gap(3);
      beat(1,  5,      0,       WS, 0,  1,  131077,  0);
      beat(0,  0,      50,      WS, 0,  1,  0,       0);
      beat(0,  0,      60,      WS, 0,  0,  0,       131072);

      // Async reset between edges with beats still in flight.
      @(posedge CLK);
      #3;
      RST_N = 1'b0;
      in_valid = 1'b0; in_a = '0; in_b = '0; in_d = '0;
      in_df = 1'b0; in_shift = '0; in_prop = 1'b0;
      for (int k = 0; k < NDUT; k++) sbq[k].delete();
      repeat (2) @(posedge CLK);
      #2 RST_N = 1'b1;

      beat(2,  3,      0,       WS, 0,  1,  3,       0);
      beat(1,  0,      11,      WS, 0,  0,  0,       0);
      beat(1,  2,      0,       WS, 0,  1,  13,      0);
      gap(1);

      repeat (10) @(posedge CLK);
      done = 1'b1;
      repeat (3) @(posedge CLK);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
